// File: rtl/draw_pkg.sv
// Shared drawing constants and scan-position type for the tile renderers.
package draw_pkg;

    localparam int CIDX_W = 4;
    localparam int POS_W  = 10;

    localparam logic [CIDX_W-1:0] BG_IDX     = 4'h0;
    localparam logic [CIDX_W-1:0] TRANSP_IDX = 4'h0;
    localparam logic [CIDX_W-1:0] CURSOR_IDX = 4'hF;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } scan_pos_t;

endpackage

// File: rtl/scan_counter.sv
// Wrap counter 0..MAX advancing when en is high; done flags the terminal count.
// Zero latency on done; no backpressure.
module scan_counter #(
    parameter int W   = 10,
    parameter int MAX = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    assign done = (count == W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= done ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/door_grid_renderer.sv
// Draws a grid of open/closed door sprites with an optional cursor outline; 2 clk from scan
// position to color_idx, sprite_addr/sprite_sel track the live scan position; no backpressure.
module door_grid_renderer
    import draw_pkg::*;
#(
    parameter int H_TOTAL   = 800,
    parameter int V_TOTAL   = 525,
    parameter int ORIGIN_X  = 184,
    parameter int ORIGIN_Y  = 128,
    parameter int TILE_W    = 112,
    parameter int TILE_H    = 156,
    parameter int GRID_COLS = 4,
    parameter int GRID_ROWS = 1,
    parameter int CIDX_W    = draw_pkg::CIDX_W,
    parameter int BORDER    = 2,
    parameter int AW        = $clog2(TILE_W*TILE_H),
    parameter int IW        = (GRID_COLS*GRID_ROWS > 1) ? $clog2(GRID_COLS*GRID_ROWS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [GRID_COLS*GRID_ROWS-1:0] tile_open,
    input  logic                           cursor_en,
    input  logic [IW-1:0]                  cursor_idx,
    output logic [AW-1:0]                  sprite_addr,
    output logic                           sprite_sel,
    input  logic [CIDX_W-1:0]              sprite_data,
    output logic [CIDX_W-1:0]              color_idx,
    output logic [9:0]                     pix_x,
    output logic [9:0]                     pix_y,
    output logic                           frame_start
);

    localparam logic [9:0] X0    = 10'(ORIGIN_X);
    localparam logic [9:0] X1    = 10'(ORIGIN_X + GRID_COLS*TILE_W);
    localparam logic [9:0] Y0    = 10'(ORIGIN_Y);
    localparam logic [9:0] Y1    = 10'(ORIGIN_Y + GRID_ROWS*TILE_H);
    localparam logic [9:0] TW_M1 = 10'(TILE_W - 1);
    localparam logic [9:0] TH_M1 = 10'(TILE_H - 1);
    localparam logic [9:0] BW    = 10'(BORDER);
    localparam logic [9:0] TW_B  = 10'(TILE_W - BORDER);
    localparam logic [9:0] TH_B  = 10'(TILE_H - BORDER);

    if (ORIGIN_X + GRID_COLS*TILE_W > H_TOTAL) begin : g_bad_x
        $error("door grid extends past H_TOTAL");
    end
    if (ORIGIN_Y + GRID_ROWS*TILE_H > V_TOTAL) begin : g_bad_y
        $error("door grid extends past V_TOTAL");
    end

    logic [9:0] x, y;
    logic       x_done, y_done;

    scan_counter #(.W(10), .MAX(H_TOTAL - 1)) u_x (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (x),
        .done  (x_done)
    );

    scan_counter #(.W(10), .MAX(V_TOTAL - 1)) u_y (
        .clk   (clk),
        .reset (reset),
        .en    (x_done),
        .count (y),
        .done  (y_done)
    );

    // Tile-local state for the pixel currently on the scan counters.
    // row_tile holds row*GRID_COLS so the tile index needs only an adder.
    logic [9:0]    tx, ty;
    logic [IW-1:0] col, row_tile;
    logic [AW-1:0] row_base;

    logic [GRID_COLS*GRID_ROWS-1:0] open_q;
    logic                           cur_en_q;
    logic [IW-1:0]                  cur_idx_q;

    logic          in_x, in_y, in_grid, h_adv, v_adv, frame_end, edge_hit;
    logic [IW-1:0] tile;
    logic [9:0]    x_n, y_n, tx_n, ty_n;
    logic [IW-1:0] col_n, row_tile_n, tile_n;
    logic [AW-1:0] addr_n, row_base_n;
    logic [GRID_COLS*GRID_ROWS-1:0] open_n;
    logic          in_grid_n, sel_n;

    assign in_x      = (x >= X0) && (x < X1);
    assign in_y      = (y >= Y0) && (y < Y1);
    assign in_grid   = in_x && in_y;
    assign h_adv     = in_grid && (x != X1 - 10'd1);
    assign v_adv     = in_y && (y != Y1 - 10'd1);
    assign frame_end = x_done && y_done;
    assign tile      = row_tile + col;
    assign edge_hit  = (tx < BW) || (tx >= TW_B) || (ty < BW) || (ty >= TH_B);

    assign x_n       = x_done ? '0 : x + 10'd1;
    assign y_n       = x_done ? (y_done ? '0 : y + 10'd1) : y;
    assign in_grid_n = (x_n >= X0) && (x_n < X1) && (y_n >= Y0) && (y_n < Y1);

    always_comb begin
        tx_n       = '0;
        col_n      = '0;
        addr_n     = row_base;
        ty_n       = ty;
        row_tile_n = row_tile;
        row_base_n = row_base;
        if (h_adv) begin
            if (tx == TW_M1) begin
                col_n = col + IW'(1);
            end else begin
                tx_n   = tx + 10'd1;
                col_n  = col;
                addr_n = sprite_addr + AW'(1);
            end
        end
        if (x_done) begin
            if (v_adv && ty == TH_M1) begin
                ty_n       = '0;
                row_tile_n = row_tile + IW'(GRID_COLS);
                row_base_n = '0;
            end else if (v_adv) begin
                ty_n       = ty + 10'd1;
                row_base_n = row_base + AW'(TILE_W);
            end else begin
                ty_n       = '0;
                row_tile_n = '0;
                row_base_n = '0;
            end
            addr_n = row_base_n;
        end
    end

    // The select for the first pixel of a frame must already see the new snapshot.
    assign open_n = frame_end ? tile_open : open_q;
    assign tile_n = row_tile_n + col_n;
    assign sel_n  = in_grid_n && open_n[tile_n];

    scan_pos_t s1_pos;
    logic      s1_grid, s1_border, s1_fs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx          <= '0;
            ty          <= '0;
            col         <= '0;
            row_tile    <= '0;
            row_base    <= '0;
            sprite_addr <= '0;
            sprite_sel  <= 1'b0;
            open_q      <= '0;
            cur_en_q    <= 1'b0;
            cur_idx_q   <= '0;
            s1_pos      <= '0;
            s1_grid     <= 1'b0;
            s1_border   <= 1'b0;
            s1_fs       <= 1'b0;
            color_idx   <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            tx          <= tx_n;
            ty          <= ty_n;
            col         <= col_n;
            row_tile    <= row_tile_n;
            row_base    <= row_base_n;
            sprite_addr <= addr_n;
            sprite_sel  <= sel_n;
            if (frame_end) begin
                open_q    <= tile_open;
                cur_en_q  <= cursor_en;
                cur_idx_q <= cursor_idx;
            end
            s1_pos.x  <= x;
            s1_pos.y  <= y;
            s1_grid   <= in_grid;
            s1_border <= cur_en_q && (tile == cur_idx_q) && edge_hit;
            s1_fs     <= (x == 10'd0) && (y == 10'd0);
            if (!s1_grid) begin
                color_idx <= CIDX_W'(BG_IDX);
            end else if (s1_border) begin
                color_idx <= CIDX_W'(CURSOR_IDX);
            end else if (sprite_data == CIDX_W'(TRANSP_IDX)) begin
                color_idx <= CIDX_W'(BG_IDX);
            end else begin
                color_idx <= sprite_data;
            end
            pix_x       <= s1_pos.x;
            pix_y       <= s1_pos.y;
            frame_start <= s1_fs;
        end
    end

endmodule

// File: tb/tb_door_grid_renderer.sv
// Scoreboarded bench for door_grid_renderer on a reduced 100x60 scan with a 3x2 grid of 20x20 tiles.
module tb_door_grid_renderer;

    localparam int H     = 100;
    localparam int V     = 60;
    localparam int OX    = 10;
    localparam int OY    = 5;
    localparam int TW    = 20;
    localparam int TH    = 20;
    localparam int COLS  = 3;
    localparam int ROWS  = 2;
    localparam int B     = 2;
    localparam int FRAME = H * V;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] tile_open = '0;
    logic       cursor_en = 1'b0;
    logic [2:0] cursor_idx = '0;
    logic [8:0] sprite_addr;
    logic       sprite_sel;
    logic [3:0] sprite_data;
    logic [3:0] color_idx;
    logic [9:0] pix_x, pix_y;
    logic       frame_start;

    int n_chk = 0;
    int n_pass = 0;

    int         mx, my;
    bit         started;
    logic [5:0] s_open;
    logic       s_cen;
    logic [2:0] s_cidx;
    logic [24:0] sb[$];

    always #5 clk = ~clk;

    door_grid_renderer #(
        .H_TOTAL(H), .V_TOTAL(V), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .TILE_W(TW), .TILE_H(TH), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
        .CIDX_W(4), .BORDER(B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tile_open   (tile_open),
        .cursor_en   (cursor_en),
        .cursor_idx  (cursor_idx),
        .sprite_addr (sprite_addr),
        .sprite_sel  (sprite_sel),
        .sprite_data (sprite_data),
        .color_idx   (color_idx),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    function automatic logic [3:0] rom_f(input logic [8:0] a, input logic s);
        logic [3:0] lo;
        lo = a[3:0];
        return s ? {lo[2:0], 1'b0} : (lo | 4'h1);
    endfunction

    always @(posedge clk) sprite_data <= rom_f(sprite_addr, sprite_sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    endtask

    function automatic void model(input int x, input int y, output logic ing,
                                  output logic [3:0] cidx, output logic sel, output int addr);
        int tx, ty, t;
        logic [3:0] d;
        ing = (x >= OX) && (x < OX + COLS*TW) && (y >= OY) && (y < OY + ROWS*TH);
        cidx = 4'h0;
        sel = 1'b0;
        addr = 0;
        if (!ing) return;
        tx = (x - OX) % TW;
        ty = (y - OY) % TH;
        t = ((y - OY) / TH) * COLS + (x - OX) / TW;
        addr = ty * TW + tx;
        sel = s_open[t];
        if (s_cen && int'(s_cidx) == t && (tx < B || tx >= TW - B || ty < B || ty >= TH - B)) begin
            cidx = 4'hF;
        end else begin
            d = rom_f(addr[8:0], sel);
            cidx = (d == 4'h0) ? 4'h0 : d;
        end
    endfunction

    task automatic model_reset();
        mx = 0;
        my = 0;
        started = 1'b0;
        sb.delete();
        s_open = '0;
        s_cen = 1'b0;
        s_cidx = '0;
    endtask

    task automatic step();
        logic ing, sel;
        logic [3:0] cidx;
        int addr;
        @(negedge clk);
        if (started) begin
            if (mx == H - 1 && my == V - 1) begin
                s_open = tile_open;
                s_cen = cursor_en;
                s_cidx = cursor_idx;
            end
            if (mx == H - 1) begin
                mx = 0;
                my = (my == V - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        started = 1'b1;
        if (sb.size() == 2) check("pix", {pix_x, pix_y, color_idx, frame_start}, sb.pop_front());
        model(mx, my, ing, cidx, sel, addr);
        sb.push_back({10'(mx), 10'(my), cidx, (mx == 0 && my == 0)});
        check("sel", 32'(sprite_sel), 32'(sel));
        if (ing) check("addr", 32'(sprite_addr), addr);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pix", {pix_x, pix_y, color_idx, frame_start}, 0);
        check("rst_rom", {sprite_addr, sprite_sel}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        run(FRAME / 2);
        tile_open = 6'b000100; cursor_en = 1'b1; cursor_idx = 3'd4;
        run(FRAME);
        tile_open = 6'b010011; cursor_en = 1'b1; cursor_idx = 3'd1;
        run(FRAME);
        tile_open = 6'b111111; cursor_en = 1'b1; cursor_idx = 3'd6;
        run(FRAME);
        tile_open = 6'b101010; cursor_en = 1'b0; cursor_idx = 3'd2;
        run(FRAME + 37);

        reset = 1'b1;
        #1;
        check("rst_mid_pix", {pix_x, pix_y, color_idx, frame_start}, 0);
        check("rst_mid_rom", {sprite_addr, sprite_sel}, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_pix", {pix_x, pix_y, color_idx, frame_start}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        run(FRAME + 1500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
